ahb_lite_manager: RTL and testbench



---
 rtl/ahb_pkg.sv | 33 +++
 rtl/ahb_lite_manager_if.sv | 27 ++
 rtl/ahb_lite_manager.sv | 145 ++++++++++++++
 tb/tb_ahb_lite_manager.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants used by the manager and the bus fabric.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_t;

  localparam logic [1:0] HSIZE_WORD    = 2'b10;
  localparam logic [6:0] HPROT_DEFAULT = 7'h03;

  typedef enum logic [2:0] {
    MGR_IDLE,
    MGR_ADDR,
    MGR_BURST,
    MGR_DATA,
    MGR_ERR1
  } mgr_state_t;

endpackage

// File: rtl/ahb_lite_manager_if.sv
// AHB-Lite shared signal set with manager (master) and subordinate (slave) views.
interface ahb_lite_manager_if;
  import ahb_pkg::*;

  logic [31:0] HADDR;
  hburst_t     HBURST;
  logic        HMASTLOCK;
  logic [6:0]  HPROT;
  logic [1:0]  HSIZE;
  htrans_t     HTRANS;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWSTRB, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWSTRB, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns command/response requests into SINGLE or INCR4 word transfers.
// Define AHB_MGR_INCR4_EN to honour cmd_incr4; otherwise every command is a SINGLE.
module ahb_lite_manager
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_incr4,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  ahb_lite_manager_if.master ahb
);

  mgr_state_t state;
  logic       last_beat;

`ifdef AHB_MGR_INCR4_EN
  logic [1:0] beat_cnt;
  assign last_beat = (ahb.HBURST != BURST_INCR4) || (beat_cnt == 2'd3);
`else
  logic unused_incr4;
  assign unused_incr4 = cmd_incr4;
  assign last_beat    = 1'b1;
`endif

  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HPROT     = HPROT_DEFAULT;
  assign ahb.HSIZE     = HSIZE_WORD;

  // NOTE: wr_ready must see this cycle's HREADY, so it is combinational; the data it
  // strobes is registered into HWDATA at the same edge the address phase retires.
  assign wr_ready = (state == MGR_ADDR || state == MGR_BURST) && ahb.HREADY && ahb.HWRITE;

  // NOTE: every state register uses <= so all of them update together at the clock edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= MGR_IDLE;
      cmd_ready  <= 1'b0;
      ahb.HTRANS <= TRANS_IDLE;
      ahb.HADDR  <= 32'h0;
      ahb.HBURST <= BURST_SINGLE;
      ahb.HWRITE <= 1'b0;
      ahb.HWSTRB <= 4'h0;
      ahb.HWDATA <= 32'h0;
      rd_data    <= 32'h0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef AHB_MGR_INCR4_EN
      beat_cnt   <= 2'd0;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (wr_ready) ahb.HWDATA <= wr_data;

      case (state)
        MGR_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            ahb.HTRANS <= TRANS_NONSEQ;
            ahb.HWRITE <= cmd_write;
            ahb.HWSTRB <= cmd_write ? 4'hF : 4'h0;
`ifdef AHB_MGR_INCR4_EN
            // INCR4 starts on a 16-byte boundary so the burst never crosses 1 KB.
            if (cmd_incr4) begin
              ahb.HADDR  <= {cmd_addr[31:4], 4'h0};
              ahb.HBURST <= BURST_INCR4;
            end else begin
              ahb.HADDR  <= {cmd_addr[31:2], 2'b00};
              ahb.HBURST <= BURST_SINGLE;
            end
            beat_cnt <= 2'd0;
`else
            ahb.HADDR  <= {cmd_addr[31:2], 2'b00};
            ahb.HBURST <= BURST_SINGLE;
`endif
            state <= MGR_ADDR;
          end
        end

        MGR_ADDR, MGR_BURST: begin
          if (ahb.HREADY) begin
            if (state == MGR_BURST && !ahb.HWRITE && !ahb.HRESP) begin
              rd_data  <= ahb.HRDATA;
              rd_valid <= 1'b1;
            end
            if (last_beat) begin
              ahb.HTRANS <= TRANS_IDLE;
              state      <= MGR_DATA;
            end
`ifdef AHB_MGR_INCR4_EN
            else begin
              ahb.HTRANS <= TRANS_SEQ;
              ahb.HADDR  <= ahb.HADDR + 32'd4;
              beat_cnt   <= beat_cnt + 2'd1;
              state      <= MGR_BURST;
            end
`endif
          end else if (state == MGR_BURST && ahb.HRESP) begin
            // First ERROR cycle: drop the pending SEQ and cancel the rest of the burst.
            ahb.HTRANS <= TRANS_IDLE;
            state      <= MGR_ERR1;
          end
        end

        MGR_DATA: begin
          if (ahb.HREADY) begin
            if (!ahb.HWRITE && !ahb.HRESP) begin
              rd_data  <= ahb.HRDATA;
              rd_valid <= 1'b1;
            end
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= MGR_IDLE;
          end else if (ahb.HRESP) begin
            state <= MGR_ERR1;
          end
        end

        MGR_ERR1: begin
          if (ahb.HREADY) begin
            done      <= 1'b1;
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= MGR_IDLE;
          end
        end

        default: state <= MGR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Self-checking bench for ahb_lite_manager: directed cases plus randomized commands
// against a transaction-level model of addresses, data, and completion timing.
`timescale 1ns/1ps
module tb_ahb_lite_manager;
  import ahb_pkg::*;

`ifdef AHB_MGR_INCR4_EN
  localparam bit INCR4_EN = 1'b1;
`else
  localparam bit INCR4_EN = 1'b0;
`endif

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_incr4 = 1'b0;
  logic [31:0] cmd_addr  = 32'h0;
  logic [31:0] wr_data   = 32'h0;
  logic        cmd_ready, wr_ready, rd_valid, done, err;
  logic [31:0] rd_data;

  ahb_lite_manager_if ahb();

  ahb_lite_manager dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_incr4 (cmd_incr4),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .ahb       (ahb)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one command starting at the current negedge and act as the subordinate until
  // done. Expected timing: address phase of beat 0 takes one cycle, each data phase takes
  // 1 + waits cycles, an ERROR adds its waits plus two response cycles, done follows.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input bit inc4,
                         input int waits[4], input int err_beat,
                         input logic [31:0] wd[4], input logic [31:0] rv[4]);
    bit          burst, has_err, fin, dp, accepted, prev_wr_ready, exp_rv;
    int          n, exp_done, exp_acc, exp_rd, acc, rdn, wcnt, c, dp_beat, wait_left, err_stage;
    logic [31:0] base, exp_rdata;

    burst    = inc4 && INCR4_EN;
    n        = burst ? 4 : 1;
    base     = burst ? {addr[31:4], 4'h0} : {addr[31:2], 2'b00};
    has_err  = (err_beat >= 0) && (err_beat < n);
    exp_done = 2;
    if (has_err) begin
      for (int k = 0; k < err_beat; k++) exp_done += 1 + waits[k];
      exp_done += waits[err_beat] + 2;
      exp_acc = err_beat + 1;
      exp_rd  = wr ? 0 : err_beat;
    end else begin
      for (int k = 0; k < n; k++) exp_done += 1 + waits[k];
      exp_acc = n;
      exp_rd  = wr ? 0 : n;
    end

    acc = 0; rdn = 0; wcnt = 0; c = 0; dp = 0; dp_beat = 0; wait_left = 0; err_stage = 0;
    fin = 0; prev_wr_ready = 0; exp_rv = 0; exp_rdata = 32'h0;

    check("cmd_ready_at_accept", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_incr4  = inc4;
    wr_data    = wd[0];
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;

    while (!fin) begin
      @(negedge HCLK);
      c++;
      if (prev_wr_ready) wcnt++;
      wr_data = wd[(wcnt > 3) ? 3 : wcnt];

      check("rd_valid", rd_valid, exp_rv);
      if (exp_rv) check("rd_data", rd_data, exp_rdata);
      if (rd_valid) rdn++;
      exp_rv = 0;

      if (done) begin
        check("done_cycle", c, exp_done);
        check("err", err, has_err);
        fin        = 1;
        cmd_valid  = 1'b0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
      end else if (c > exp_done + 4) begin
        check("done_timeout", c, exp_done);
        fin        = 1;
        cmd_valid  = 1'b0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
      end else begin
        // Commands presented while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_incr4 = 1'($urandom_range(0, 1));

        accepted = 0;
        if (dp) begin
          if (err_stage == 1) begin
            check("htrans_after_err", ahb.HTRANS, TRANS_IDLE);
            ahb.HREADY = 1'b1;
            ahb.HRESP  = 1'b1;
            err_stage  = 2;
            dp         = 0;
          end else if (wait_left > 0) begin
            ahb.HREADY = 1'b0;
            ahb.HRESP  = 1'b0;
            wait_left--;
            if (wr) check("hwdata_hold", ahb.HWDATA, wd[dp_beat]);
          end else if (dp_beat == err_beat) begin
            ahb.HREADY = 1'b0;
            ahb.HRESP  = 1'b1;
            err_stage  = 1;
          end else begin
            ahb.HREADY = 1'b1;
            ahb.HRESP  = 1'b0;
            if (wr) check("hwdata", ahb.HWDATA, wd[dp_beat]);
            else begin
              ahb.HRDATA = rv[dp_beat];
              exp_rv     = 1;
              exp_rdata  = rv[dp_beat];
            end
            dp = 0;
          end
        end else begin
          ahb.HREADY = 1'b1;
          ahb.HRESP  = 1'b0;
        end

        if ((ahb.HTRANS == TRANS_NONSEQ || ahb.HTRANS == TRANS_SEQ) && ahb.HREADY) begin
          check("haddr", ahb.HADDR, base + 32'(4 * acc));
          check("htrans", ahb.HTRANS, (acc == 0) ? TRANS_NONSEQ : TRANS_SEQ);
          check("hburst", ahb.HBURST, burst ? 32'd3 : 32'd0);
          check("hwrite", ahb.HWRITE, wr);
          check("hwstrb", ahb.HWSTRB, wr ? 32'hF : 32'h0);
          dp        = 1;
          dp_beat   = (acc > 3) ? 3 : acc;
          wait_left = waits[dp_beat];
          accepted  = 1;
          acc++;
        end

        #1;
        check("wr_ready", wr_ready, accepted && wr);
        prev_wr_ready = wr_ready;
      end
    end

    check("addr_beats", acc, exp_acc);
    if (wr) check("wr_beats", wcnt, exp_acc);
    else    check("rd_beats", rdn, exp_rd);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge HCLK);
      check("idle_done", done, 0);
      check("idle_ready", cmd_ready, 1);
    end
  endtask

  int          w[4];
  logic [31:0] wd[4];
  logic [31:0] rv[4];
  int          eb;
  bit          r_wr, r_inc;

  initial begin
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = 32'h0;

    // Reset values
    repeat (2) @(negedge HCLK);
    check("rst_htrans", ahb.HTRANS, TRANS_IDLE);
    check("rst_haddr", ahb.HADDR, 32'h0);
    check("rst_hburst", ahb.HBURST, 32'h0);
    check("rst_hwrite", ahb.HWRITE, 0);
    check("rst_hsize", ahb.HSIZE, 32'h2);
    check("rst_hprot", ahb.HPROT, 32'h03);
    check("rst_hwstrb", ahb.HWSTRB, 32'h0);
    check("rst_hwdata", ahb.HWDATA, 32'h0);
    check("rst_hmastlock", ahb.HMASTLOCK, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("ready_after_rst", cmd_ready, 1);

    // SINGLE write to unaligned address, zero wait
    w  = '{0, 0, 0, 0};
    wd = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    rv = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_cmd(1'b1, 32'h4000_0013, 1'b0, w, -1, wd, rv);
    idle(1);

    // INCR4 read (a SINGLE when bursts are disabled), data 1..4
    rv = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_cmd(1'b0, 32'h0000_0100, 1'b1, w, -1, wd, rv);
    idle(1);

    // INCR4 write with two wait states on beat 2
    w  = '{0, 0, 2, 0};
    wd = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    run_cmd(1'b1, 32'h0000_0100, 1'b1, w, -1, wd, rv);
    idle(1);

    // INCR4 read with ERROR on beat 1, then a SINGLE read ERROR back to back
    w = '{0, 0, 0, 0};
    run_cmd(1'b0, 32'h0000_0200, 1'b1, w, 1, wd, rv);
    run_cmd(1'b0, 32'h0000_0204, 1'b0, w, 0, wd, rv);
    idle(1);

    // Reset in the middle of a transfer
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_incr4 = 1'b1; cmd_addr = 32'h0000_0300;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    ahb.HREADY = 1'b0;
    check("pre_rst_haddr", ahb.HADDR, INCR4_EN ? 32'h304 : 32'h300);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_htrans", ahb.HTRANS, TRANS_IDLE);
    check("midrst_haddr", ahb.HADDR, 32'h0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge HCLK);
    ahb.HREADY = 1'b1;
    HRESETn    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check("postrst_no_done", done, 0);
    end
    check("postrst_cmd_ready", cmd_ready, 1);

    // Randomized commands with wait states and errors
    for (int t = 0; t < 60; t++) begin
      r_wr  = 1'($urandom_range(0, 1));
      r_inc = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        w[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        wd[k] = $urandom;
        rv[k] = $urandom;
      end
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd(r_wr, $urandom, r_inc, w, eb, wd, rv);
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
